// File: rtl/attractor_detector_pkg.sv
// Shared types and width helpers for the attractor detector.
//   det_state_t      : 2-bit FSM state code
//   IDLE/TRACK/LOCKED/TIMEOUT : state constants
//   period_width()   : bits needed to hold a period in 0..hist_depth
//   confirm_width()  : bits needed to hold a confirm count in 0..stable_count
package attractor_detector_pkg;

    typedef logic [1:0] det_state_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TRACK   = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] TIMEOUT = 2'd3;

    function automatic int unsigned period_width(input int unsigned hist_depth);
        return $clog2(hist_depth + 1);
    endfunction

    function automatic int unsigned confirm_width(input int unsigned stable_count);
        return $clog2(stable_count + 1);
    endfunction

endpackage

// File: rtl/attractor_detector_history_match.sv
// Compares the incoming state against every valid history entry and reports
// the smallest matching period (entry k, 0 = most recent, means period k+1).
//   hist          : history entries, index 0 most recent
//   hist_valid    : per-entry valid bits
//   network_state : state being sampled this cycle
//   hit_c         : some valid entry matches (combinational)
//   period_c      : smallest matching period, 0 when no hit (combinational)
module attractor_detector_history_match
    import attractor_detector_pkg::*;
#(
    parameter int unsigned N_NODES    = 64,
    parameter int unsigned HIST_DEPTH = 8,
    localparam int unsigned PERIOD_W  = period_width(HIST_DEPTH)
) (
    input  logic [HIST_DEPTH-1:0][N_NODES-1:0] hist,
    input  logic [HIST_DEPTH-1:0]              hist_valid,
    input  logic [N_NODES-1:0]                 network_state,
    output logic                               hit_c,
    output logic [PERIOD_W-1:0]                period_c
);

    // Scan oldest to newest so the most recent (shortest period) match wins.
    always_comb begin
        hit_c    = 1'b0;
        period_c = '0;
        for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
            if (hist_valid[k] && (hist[k] == network_state)) begin
                hit_c    = 1'b1;
                period_c = PERIOD_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/attractor_detector.sv
// Detects when the sampled network state has settled into a fixed point or a
// short cycle, and flags a timeout when none is found by MAX_ITER.
//   clk, rst          : clock, synchronous active-high reset
//   start             : clear history and begin tracking (from any state)
//   sample            : network_state / iteration_number valid this cycle
//   network_state     : current node values
//   iteration_number  : controlpath iteration count
//   busy              : tracking in progress
//   is_steady_state   : attractor locked
//   attractor_period  : locked period (1 = fixed point)
//   attractor_iter    : iteration_number of the confirming sample
//   timeout           : no attractor found by MAX_ITER
module attractor_detector
    import attractor_detector_pkg::*;
#(
    parameter int unsigned N_NODES      = 64,
    parameter int unsigned HIST_DEPTH   = 8,
    parameter int unsigned STABLE_COUNT = 4,
    parameter int unsigned MAX_ITER     = 1000,
    parameter int unsigned ITER_W       = 10,
    localparam int unsigned PERIOD_W    = period_width(HIST_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sample,
    input  logic [N_NODES-1:0]  network_state,
    input  logic [ITER_W-1:0]   iteration_number,
    output logic                busy,
    output logic                is_steady_state,
    output logic [PERIOD_W-1:0] attractor_period,
    output logic [ITER_W-1:0]   attractor_iter,
    output logic                timeout
);

    localparam int unsigned     CONF_W   = confirm_width(STABLE_COUNT);
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(STABLE_COUNT);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER);

    det_state_t                         state_q, state_d;
    logic [HIST_DEPTH-1:0][N_NODES-1:0] hist_q, hist_d;
    logic [HIST_DEPTH-1:0]              valid_q, valid_d;
    logic [PERIOD_W-1:0]                cand_q, cand_d;
    logic [CONF_W-1:0]                  conf_q, conf_d;
    logic [PERIOD_W-1:0]                period_d;
    logic [ITER_W-1:0]                  iter_d;
    logic                               hit_c;
    logic [PERIOD_W-1:0]                match_period_c;

    attractor_detector_history_match #(
        .N_NODES    (N_NODES),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_match (
        .hist          (hist_q),
        .hist_valid    (valid_q),
        .network_state (network_state),
        .hit_c         (hit_c),
        .period_c      (match_period_c)
    );

    // Next-state, candidate/confirm tracking and history shift.
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        valid_d  = valid_q;
        cand_d   = cand_q;
        conf_d   = conf_q;
        period_d = attractor_period;
        iter_d   = attractor_iter;

        if (start) begin
            // A sample arriving together with start is dropped here.
            state_d  = TRACK;
            valid_d  = '0;
            cand_d   = '0;
            conf_d   = '0;
            period_d = '0;
            iter_d   = '0;
        end else if ((state_q == TRACK) && sample) begin
            if (hit_c) begin
                if (match_period_c == cand_q) begin
                    if (conf_q != CONF_MAX) conf_d = conf_q + CONF_W'(1);
                end else begin
                    cand_d = match_period_c;
                    conf_d = CONF_W'(1);
                end
            end else begin
                cand_d = '0;
                conf_d = '0;
            end

            hist_d[0]  = network_state;
            valid_d[0] = 1'b1;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist_d[k]  = hist_q[k-1];
                valid_d[k] = valid_q[k-1];
            end

            // Lock takes priority over timeout on the same sample.
            if (conf_d == CONF_MAX) begin
                state_d  = LOCKED;
                period_d = cand_d;
                iter_d   = iteration_number;
            end else if (iteration_number == ITER_LAST) begin
                state_d = TIMEOUT;
            end
        end
    end

    // State, control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            valid_q          <= '0;
            cand_q           <= '0;
            conf_q           <= '0;
            busy             <= 1'b0;
            is_steady_state  <= 1'b0;
            timeout          <= 1'b0;
            attractor_period <= '0;
            attractor_iter   <= '0;
        end else begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            cand_q           <= cand_d;
            conf_q           <= conf_d;
            busy             <= (state_d == TRACK);
            is_steady_state  <= (state_d == LOCKED);
            timeout          <= (state_d == TIMEOUT);
            attractor_period <= period_d;
            attractor_iter   <= iter_d;
        end
    end

    // History payload needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

endmodule
